// File: rtl/dec_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dec_seq_ctrl
// Debounced switch/button front end that drives the 2-to-3 LED decoder
// select in manual, auto-scan or pause mode.
// Rev    : 1.0
// ============================================================================
module dec_seq_ctrl #(
   parameter int DIV       = 12_500_000,
   parameter int DB_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] switch,
   input  logic       btn,
   output logic [1:0] sel,
   output logic [2:0] led,
   output logic [1:0] mode,
   output logic       tick
);
   localparam int C_PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int C_DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [C_PW-1:0] C_PRE_LAST = C_PW'(DIV - 1);
   localparam logic [C_DW-1:0] C_DB_LAST  = C_DW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_MANUAL = 2'b00,
      ST_AUTO   = 2'b01,
      ST_PAUSE  = 2'b10
   } state_t;

   logic [1:0]      sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d, sw_db_q, sw_db_d;
   logic [C_DW-1:0] sw_cnt_q, sw_cnt_d;
   logic            btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d, btn_db_q, btn_db_d;
   logic [C_DW-1:0] btn_cnt_q, btn_cnt_d;
   logic            btn_prev_q, btn_prev_d;
   state_t          state_q, state_d;
   logic [1:0]      sel_q, sel_d;
   logic            tick_q, tick_d;
   logic [C_PW-1:0] pre_q, pre_d;
   logic            press;

   // Synchronisers and debounce filters; a filter accepts the synced value
   // only after it has differed from the accepted value for DB_CYCLES edges.
   always_comb begin
      sw_s1_d  = switch;
      sw_s2_d  = sw_s1_q;
      sw_db_d  = sw_db_q;
      sw_cnt_d = '0;
      if (sw_s2_q != sw_db_q) begin
         if (sw_cnt_q == C_DB_LAST) sw_db_d  = sw_s2_q;
         else                       sw_cnt_d = sw_cnt_q + 1'b1;
      end

      btn_s1_d  = btn;
      btn_s2_d  = btn_s1_q;
      btn_db_d  = btn_db_q;
      btn_cnt_d = '0;
      if (btn_s2_q != btn_db_q) begin
         if (btn_cnt_q == C_DB_LAST) btn_db_d  = btn_s2_q;
         else                        btn_cnt_d = btn_cnt_q + 1'b1;
      end
      btn_prev_d = btn_db_q;
   end

   assign press = btn_db_q & ~btn_prev_q;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      tick_d  = 1'b0;
      pre_d   = pre_q;
      case (state_q)
         ST_MANUAL: begin
            sel_d = sw_db_q;
            if (press) begin
               state_d = ST_AUTO;
               pre_d   = '0;
            end
         end
         ST_AUTO: begin
            // A press on the step cycle suppresses the step.
            if (press) begin
               state_d = ST_PAUSE;
            end else if (pre_q == C_PRE_LAST) begin
               pre_d  = '0;
               sel_d  = sel_q + 2'd1;
               tick_d = 1'b1;
            end else begin
               pre_d = pre_q + 1'b1;
            end
         end
         ST_PAUSE: begin
            if (press) state_d = ST_MANUAL;
         end
         default: state_d = ST_MANUAL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         sw_db_q    <= '0;
         sw_cnt_q   <= '0;
         btn_s1_q   <= 1'b0;
         btn_s2_q   <= 1'b0;
         btn_db_q   <= 1'b0;
         btn_cnt_q  <= '0;
         btn_prev_q <= 1'b0;
         state_q    <= ST_MANUAL;
         sel_q      <= '0;
         tick_q     <= 1'b0;
         pre_q      <= '0;
      end else begin
         sw_s1_q    <= sw_s1_d;
         sw_s2_q    <= sw_s2_d;
         sw_db_q    <= sw_db_d;
         sw_cnt_q   <= sw_cnt_d;
         btn_s1_q   <= btn_s1_d;
         btn_s2_q   <= btn_s2_d;
         btn_db_q   <= btn_db_d;
         btn_cnt_q  <= btn_cnt_d;
         btn_prev_q <= btn_prev_d;
         state_q    <= state_d;
         sel_q      <= sel_d;
         tick_q     <= tick_d;
         pre_q      <= pre_d;
      end
   end

   always_comb begin
      led = 3'b000;
      case (sel_q)
         2'b01:   led = 3'b001;
         2'b10:   led = 3'b010;
         2'b11:   led = 3'b100;
         default: led = 3'b000;
      endcase
   end

   assign sel  = sel_q;
   assign mode = state_q;
   assign tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dec_seq_ctrl
// Directed bench for dec_seq_ctrl with a cycle-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_dec_seq_ctrl;
   localparam int DIV = 4;
   localparam int DB  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] switch;
   logic       btn;
   logic [1:0] sel;
   logic [2:0] led;
   logic [1:0] mode;
   logic       tick;

   int n_cmp = 0;
   int n_bad = 0;

   dec_seq_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
      .clk(clk), .rst(rst), .switch(switch), .btn(btn),
      .sel(sel), .led(led), .mode(mode), .tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: pins reach the filter two cycles late; a filter takes
   // the new value on the DB-th consecutive edge where it disagrees.
   int m_sw_pipe[2], m_bt_pipe[2];
   int m_sw_db, m_sw_run, m_bt_db, m_bt_run, m_bt_prev;
   int m_mode, m_sel, m_age, m_tick;
   bit m_valid = 1'b0;

   task automatic filt(input int s, inout int db, inout int run);
      if (s == db) run = 0;
      else begin
         run++;
         if (run == DB) begin
            db  = s;
            run = 0;
         end
      end
   endtask

   initial forever begin
      bit pr;
      @(posedge clk);
      if (rst) begin
         m_sw_pipe[0] = 0; m_sw_pipe[1] = 0; m_bt_pipe[0] = 0; m_bt_pipe[1] = 0;
         m_sw_db = 0; m_sw_run = 0; m_bt_db = 0; m_bt_run = 0; m_bt_prev = 0;
         m_mode = 0; m_sel = 0; m_age = 0; m_tick = 0;
      end else begin
         pr     = (m_bt_db == 1) && (m_bt_prev == 0);
         m_tick = 0;
         case (m_mode)
            0: begin
               m_sel = m_sw_db;
               if (pr) begin m_mode = 1; m_age = 0; end
            end
            1: begin
               if (pr) m_mode = 2;
               else begin
                  if (m_age % DIV == DIV - 1) begin
                     m_sel  = (m_sel + 1) % 4;
                     m_tick = 1;
                  end
                  m_age++;
               end
            end
            default: if (pr) m_mode = 0;
         endcase
         m_bt_prev = m_bt_db;
         filt(m_sw_pipe[1], m_sw_db, m_sw_run);
         filt(m_bt_pipe[1], m_bt_db, m_bt_run);
         m_sw_pipe[1] = m_sw_pipe[0]; m_sw_pipe[0] = int'(switch);
         m_bt_pipe[1] = m_bt_pipe[0]; m_bt_pipe[0] = int'(btn);
      end
      m_valid = 1'b1;
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("model_sel",  32'(sel),  m_sel);
         chk("model_led",  32'(led),  (m_sel == 0) ? 0 : (1 << (m_sel - 1)));
         chk("model_mode", 32'(mode), m_mode);
         chk("model_tick", 32'(tick), m_tick);
      end
   end

   // Returns on the negedge right after the FSM has reacted to the press.
   task automatic press_btn();
      btn = 1'b1;
      repeat (5) @(negedge clk);
      btn = 1'b0;
      @(negedge clk);
   endtask

   int exp_sel[4] = '{0, 1, 2, 3};
   int exp_led[4] = '{0, 1, 2, 4};

   initial begin
      rst    = 1'b1;
      switch = 2'($urandom);
      btn    = 1'($urandom);
      @(negedge clk);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_led", 32'(led), 0);
      chk("rst_mode", 32'(mode), 0);
      chk("rst_tick", 32'(tick), 0);
      @(negedge clk);
      rst = 1'b0; switch = 2'b00; btn = 1'b0;
      repeat (8) @(negedge clk);

      // Manual latency and glitch rejection
      switch = 2'b11;
      repeat (5) @(negedge clk);
      chk("man_sel_early", 32'(sel), 0);
      @(negedge clk);
      chk("man_sel", 32'(sel), 3);
      chk("man_led", 32'(led), 4);
      switch = 2'b01;
      repeat (2) @(negedge clk);
      switch = 2'b11;
      repeat (8) @(negedge clk);
      chk("glitch_sel", 32'(sel), 3);

      // Auto scan
      press_btn();
      chk("auto_mode", 32'(mode), 1);
      chk("auto_sel0", 32'(sel), 3);
      for (int k = 0; k < 4; k++) begin
         repeat (3) @(negedge clk);
         chk("auto_tick_lo", 32'(tick), 0);
         @(negedge clk);
         chk("auto_tick_hi", 32'(tick), 1);
         chk("auto_sel", 32'(sel), exp_sel[k]);
         chk("auto_led", 32'(led), exp_led[k]);
      end

      // Pause, then back to manual with a new switch value
      press_btn();
      chk("pause_mode", 32'(mode), 2);
      chk("pause_sel0", 32'(sel), 0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("pause_sel", 32'(sel), 0);
         chk("pause_tick", 32'(tick), 0);
      end
      switch = 2'b10;
      repeat (8) @(negedge clk);
      press_btn();
      chk("resume_mode", 32'(mode), 0);
      chk("resume_sel_hold", 32'(sel), 0);
      @(negedge clk);
      chk("resume_sel", 32'(sel), 2);
      chk("resume_led", 32'(led), 2);

      // Press lands on the prescaler's last count
      repeat (4) @(negedge clk);
      press_btn();
      chk("race_entry_mode", 32'(mode), 1);
      repeat (6) @(negedge clk);
      press_btn();
      chk("race_mode", 32'(mode), 2);
      chk("race_tick", 32'(tick), 0);
      chk("race_sel", 32'(sel), 0);

      // Reset in the middle of auto, then a fresh auto entry
      repeat (6) @(negedge clk);
      press_btn();
      chk("r6_manual", 32'(mode), 0);
      repeat (7) @(negedge clk);
      press_btn();
      chk("r6_auto", 32'(mode), 1);
      chk("r6_sel", 32'(sel), 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_sel", 32'(sel), 0);
      chk("midrst_led", 32'(led), 0);
      chk("midrst_mode", 32'(mode), 0);
      chk("midrst_tick", 32'(tick), 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      press_btn();
      chk("reauto_mode", 32'(mode), 1);
      chk("reauto_sel", 32'(sel), 2);
      repeat (3) begin
         @(negedge clk);
         chk("reauto_tick_lo", 32'(tick), 0);
      end
      @(negedge clk);
      chk("reauto_tick_hi", 32'(tick), 1);
      chk("reauto_step_sel", 32'(sel), 3);
      chk("reauto_step_led", 32'(led), 4);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
